// File: rtl/comp_seq.sv
// Sequential magnitude comparator: walks WIDTH-bit operands DIGIT bits per clock,
// MSB digit first, stopping at the first differing digit. Result is {outf1,outf2,outf3} = {A>B, A==B, A<B}.
module comp_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             busy,
  output logic             done,
  output logic             outf1,
  output logic             outf2,
  output logic             outf3
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("comp_seq: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] flip;
  logic [IDX_W-1:0] idx;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [2:0]       res_n;
  logic             done_n;
  logic             load;
  logic             advance;

  assign busy  = (state == COMPARE);
  assign dig_a = a_q[WIDTH-1 -: DIGIT];
  assign dig_b = b_q[WIDTH-1 -: DIGIT];

  // Biasing the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    flip            = '0;
    flip[WIDTH-1]   = signed_mode;
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    res_n   = {outf1, outf2, outf3};
    load    = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = COMPARE;
        end
      end
      COMPARE: begin
        if (dig_a != dig_b) begin
          res_n   = (dig_a > dig_b) ? 3'b100 : 3'b001;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (idx == IDX_W'(N - 1)) begin
          res_n   = 3'b010;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      done                  <= 1'b0;
      {outf1, outf2, outf3} <= 3'b000;
      a_q                   <= '0;
      b_q                   <= '0;
      idx                   <= '0;
    end else begin
      state                 <= state_n;
      done                  <= done_n;
      {outf1, outf2, outf3} <= res_n;
      if (load) begin
        a_q <= ina ^ flip;
        b_q <= inb ^ flip;
        idx <= '0;
      end else if (advance) begin
        a_q <= a_q << DIGIT;
        b_q <= b_q << DIGIT;
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comp_seq.sv
// Directed bench for comp_seq: an 8-bit/2-bit-digit instance and a 2-bit/1-bit-digit
// instance swept exhaustively in both modes.
module tb_comp_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       signed_mode;
  logic [7:0] ina;
  logic [7:0] inb;
  logic       busy;
  logic       done;
  logic       outf1;
  logic       outf2;
  logic       outf3;

  logic       start2;
  logic       sm2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       busy2;
  logic       done2;
  logic       o2_gt;
  logic       o2_eq;
  logic       o2_lt;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  comp_seq #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .ina(ina), .inb(inb), .busy(busy), .done(done),
    .outf1(outf1), .outf2(outf2), .outf3(outf3)
  );

  comp_seq #(.WIDTH(2), .DIGIT(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2),
    .ina(a2), .inb(b2), .busy(busy2), .done(done2),
    .outf1(o2_gt), .outf2(o2_eq), .outf3(o2_lt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!done && lat < 20);
  endtask

  task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sm, input int exp_lat, input logic [2:0] exp_res);
    int lat;
    ina = a; inb = b; signed_mode = sm; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy_after_accept"}, busy, 1'b1);
    wait_done(lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, {outf1, outf2, outf3}, exp_res);
    check({tag, " busy_at_done"}, busy, 1'b0);
    tick();
    check({tag, " done_one_cycle"}, done, 1'b0);
    check({tag, " result_held"}, {outf1, outf2, outf3}, exp_res);
  endtask

  initial begin
    int lat;
    int cnt0;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; ina = '0; inb = '0;
    start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset outf", {outf1, outf2, outf3}, 3'b000);
    check("reset2 busy/done/outf", {busy2, done2, o2_gt, o2_eq, o2_lt}, 5'b0);
    tick();
    check("idle done", done, 1'b0);

    // Equal operands run all four digits.
    run_cmp("t1 a5==a5", 8'hA5, 8'hA5, 1'b0, 4, EQ);

    // Sign mode flips the outcome of the MSB digit.
    run_cmp("t2 80>7f u", 8'h80, 8'h7F, 1'b0, 1, GT);
    run_cmp("t2 80<7f s", 8'h80, 8'h7F, 1'b1, 1, LT);

    // Back-to-back: start held across the done cycle, operands changed while busy.
    ina = 8'h13; inb = 8'h12; signed_mode = 1'b0; start = 1'b1;
    tick();
    ina = 8'h12; inb = 8'h13;
    wait_done(lat);
    check("t3 first latency", lat, 4);
    check("t3 first result", {outf1, outf2, outf3}, GT);
    tick();
    check("t3 no gap busy", busy, 1'b1);
    check("t3 no gap done", done, 1'b0);
    check("t3 held during second", {outf1, outf2, outf3}, GT);
    start = 1'b0;
    wait_done(lat);
    check("t3 second latency", lat, 4);
    check("t3 second result", {outf1, outf2, outf3}, LT);
    tick();

    // Start pulse and operand change mid-compare are ignored.
    ina = 8'h40; inb = 8'h41; start = 1'b1;
    tick();
    start = 1'b0;
    cnt0 = done_cnt;
    tick();
    start = 1'b1; ina = 8'hFF;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("t4 remaining latency", lat, 2);
    check("t4 result", {outf1, outf2, outf3}, LT);
    tick();
    tick();
    check("t4 single done", done_cnt - cnt0, 1);
    check("t4 not queued", busy, 1'b0);

    // Reset mid-compare aborts without a done pulse.
    run_cmp("t5 pre", 8'h80, 8'h7F, 1'b0, 1, GT);
    ina = 8'h13; inb = 8'h12; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    cnt0 = done_cnt;
    tick();
    rst = 1'b0;
    check("t5 rst busy", busy, 1'b0);
    check("t5 rst done", done, 1'b0);
    check("t5 rst outf", {outf1, outf2, outf3}, 3'b000);
    repeat (5) tick();
    check("t5 no done after abort", done_cnt - cnt0, 0);
    run_cmp("t5 post", 8'hA5, 8'hA5, 1'b0, 4, EQ);

    // Exhaustive 2-bit sweep against an integer model.
    for (int sm = 0; sm < 2; sm++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          int sa;
          int sb;
          int exp_lat;
          logic [2:0] exp_res;
          sa = (sm == 1 && a >= 2) ? a - 4 : a;
          sb = (sm == 1 && b >= 2) ? b - 4 : b;
          exp_res = (sa > sb) ? GT : (sa == sb) ? EQ : LT;
          exp_lat = ((a / 2) != (b / 2)) ? 1 : 2;
          a2 = 2'(a); b2 = 2'(b); sm2 = sm[0]; start2 = 1'b1;
          tick();
          start2 = 1'b0;
          lat = 0;
          do begin
            tick();
            lat++;
          end while (!done2 && lat < 20);
          check($sformatf("t6 sm%0d %0d vs %0d latency", sm, a, b), lat, exp_lat);
          check($sformatf("t6 sm%0d %0d vs %0d result", sm, a, b), {o2_gt, o2_eq, o2_lt}, exp_res);
          tick();
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
